// File: rtl/display_scan_if.sv
`default_nettype none
// ============================================================================
// display_scan_if : control/status bundle between user-project top and scanner
// Rev 1.0
// ============================================================================
interface display_scan_if #(
  parameter int DWELL_W = 16
);
  logic               enable;
  logic               mode_manual;
  logic [2:0]         manual_sel;
  logic [4:0]         chan_mask;
  logic [DWELL_W-1:0] dwell;
  logic [4:0]         select;
  logic [2:0]         chan_id;
  logic               sample_valid;
  logic               frame_done;
  logic               busy;

  modport master (
    output enable, mode_manual, manual_sel, chan_mask, dwell,
    input  select, chan_id, sample_valid, frame_done, busy
  );

  modport slave (
    input  enable, mode_manual, manual_sel, chan_mask, dwell,
    output select, chan_id, sample_valid, frame_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_controller.sv
`default_nettype none
// ============================================================================
// display_scan_controller : one-hot select sequencer for the 5:1 display mux
// Rev 1.0
// ============================================================================
module display_scan_controller #(
  parameter int DWELL_W = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,
  display_scan_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [1:0]         r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_last;
  logic [4:0]         r_select;
  logic [2:0]         r_chan_id;
  logic               r_sv;
  logic               r_fd;
  logic               r_busy;
  logic               r_pinned;

  logic [2:0]         w_manual_idx;
  logic [DWELL_W-1:0] w_dwell_last;
  logic [2:0]         w_lowest;
  logic [2:0]         w_above;
  logic               w_found_above;
  logic [2:0]         w_next_idx;
  logic               w_boundary;
  logic               w_override;
  logic [1:0]         w_state_nxt;
  logic               w_load;
  logic [2:0]         w_load_idx;
  logic               w_load_pin;
  logic               w_frame;

  assign w_manual_idx = (bus.manual_sel > 3'd4) ? 3'd0 : bus.manual_sel;
  assign w_dwell_last = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

  // Descending scan: the last hit is the lowest set bit; 'above' keeps the
  // smallest set bit strictly greater than the current channel.
  always_comb begin
    w_lowest      = 3'd0;
    w_above       = 3'd0;
    w_found_above = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (bus.chan_mask[i]) begin
        w_lowest = 3'(i);
        if (3'(i) > r_chan_id) begin
          w_above       = 3'(i);
          w_found_above = 1'b1;
        end
      end
    end
    w_next_idx = w_found_above ? w_above : w_lowest;
  end

  assign w_boundary = (r_state == S_HOLD) && (r_cnt == r_last);
  // A pinned channel that no longer matches manual_sel, or manual mode
  // arriving while auto-scanning, aborts the dwell immediately.
  assign w_override = (r_state == S_HOLD) && bus.mode_manual &&
                      (!r_pinned || (w_manual_idx != r_chan_id));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = r_chan_id;
    w_load_pin  = r_pinned;
    w_frame     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          if (bus.mode_manual) begin
            w_load      = 1'b1;
            w_load_idx  = w_manual_idx;
            w_load_pin  = 1'b1;
            w_state_nxt = S_SETTLE;
          end else if (bus.chan_mask != 5'd0) begin
            w_load      = 1'b1;
            w_load_idx  = w_lowest;
            w_load_pin  = 1'b0;
            w_state_nxt = S_SETTLE;
          end
        end
      end
      S_SETTLE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_boundary && !bus.enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_override || (w_boundary && bus.mode_manual)) begin
          w_load      = 1'b1;
          w_load_idx  = w_manual_idx;
          w_load_pin  = 1'b1;
          w_state_nxt = S_SETTLE;
        end else if (w_boundary) begin
          if (bus.chan_mask != 5'd0) begin
            w_load      = 1'b1;
            w_load_idx  = w_next_idx;
            w_load_pin  = 1'b0;
            w_frame     = (w_next_idx <= r_chan_id);
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= '0;
      r_select  <= 5'b00001;
      r_chan_id <= 3'd0;
      r_sv      <= 1'b0;
      r_fd      <= 1'b0;
      r_busy    <= 1'b0;
      r_pinned  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      // SETTLE always hands over to HOLD, so this marks the first HOLD cycle,
      // which is when the mux register has captured the new select.
      r_sv    <= (r_state == S_SETTLE);
      r_fd    <= w_frame;
      r_cnt   <= ((r_state == S_HOLD) && (w_state_nxt == S_HOLD)) ?
                 r_cnt + DWELL_W'(1) : '0;
      if (w_load) begin
        r_select  <= 5'b00001 << w_load_idx;
        r_chan_id <= w_load_idx;
        r_pinned  <= w_load_pin;
        r_last    <= w_dwell_last;
      end
    end
  end

  assign bus.select       = r_select;
  assign bus.chan_id      = r_chan_id;
  assign bus.sample_valid = r_sv;
  assign bus.frame_done   = r_fd;
  assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_display_scan_controller : directed bench for display_scan_controller
// Rev 1.0
// ============================================================================
module tb_display_scan_controller;

  localparam int DWELL_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   seq1 [5] = '{1, 2, 3, 4, 0};
  int   cur;

  display_scan_if #(.DWELL_W(DWELL_W)) bus ();

  display_scan_controller #(.DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int idx, input logic sv,
                        input logic fd, input logic busy);
    logic [4:0] one;
    one = 5'b00001;
    chk({tag, ".select"}, 32'(bus.select), 32'(one << idx));
    chk({tag, ".chan_id"}, 32'(bus.chan_id), 32'(idx));
    chk({tag, ".sample_valid"}, 32'(bus.sample_valid), 32'(sv));
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(fd));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.enable      = 1'b0;
    bus.mode_manual = 1'b0;
    bus.manual_sel  = 3'd0;
    bus.chan_mask   = 5'b11111;
    bus.dwell       = 16'd3;
    tick(); tick();
    chk_st("reset", 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk_st("idle_disabled", 0, 0, 0, 0);

    // Full rotation, dwell 3: 4 cycles per channel
    bus.enable = 1'b1;
    tick(); chk_st("t1_settle", 0, 0, 0, 1);
    tick(); chk_st("t1_first_sv", 0, 1, 0, 1);
    cur = 0;
    for (int k = 0; k < 5; k++) begin
      tick(); chk_st("t1_hold_a", cur, 0, 0, 1);
      tick(); chk_st("t1_hold_b", cur, 0, 0, 1);
      tick(); chk_st("t1_step", seq1[k], 0, (seq1[k] == 0), 1);
      tick(); chk_st("t1_sv", seq1[k], 1, 0, 1);
      cur = seq1[k];
    end

    // Mid-dwell mask/dwell change does not shorten the current HOLD
    bus.chan_mask = 5'b10100;
    bus.dwell     = 16'd1;
    tick(); chk_st("t2_keep_a", 0, 0, 0, 1);
    tick(); chk_st("t2_keep_b", 0, 0, 0, 1);
    tick(); chk_st("t2_to2", 2, 0, 0, 1);
    tick(); chk_st("t2_sv2", 2, 1, 0, 1);
    tick(); chk_st("t2_to4", 4, 0, 0, 1);
    tick(); chk_st("t2_sv4", 4, 1, 0, 1);
    tick(); chk_st("t2_wrap", 2, 0, 1, 1);
    tick(); chk_st("t2_sv2b", 2, 1, 0, 1);

    // Manual pin on channel 3, dwell 2
    bus.mode_manual = 1'b1;
    bus.manual_sel  = 3'd3;
    bus.dwell       = 16'd2;
    tick(); chk_st("t3_load", 3, 0, 0, 1);
    tick(); chk_st("t3_sv", 3, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      tick(); chk_st("t3_hold", 3, 0, 0, 1);
      tick(); chk_st("t3_refresh", 3, 0, 0, 1);
      tick(); chk_st("t3_resv", 3, 1, 0, 1);
    end
    bus.manual_sel = 3'd6;
    tick(); chk_st("t3_sel6", 0, 0, 0, 1);
    tick(); chk_st("t3_sel6_sv", 0, 1, 0, 1);

    // Manual override mid-HOLD
    bus.manual_sel = 3'd1;
    tick(); chk_st("t4_sel1", 1, 0, 0, 1);
    tick(); chk_st("t4_sel1_sv", 1, 1, 0, 1);
    bus.manual_sel = 3'd4;
    tick(); chk_st("t4_abort", 4, 0, 0, 1);
    tick(); chk_st("t4_abort_sv", 4, 1, 0, 1);

    // Enable dropped mid-HOLD: dwell completes, then IDLE with select held
    bus.enable = 1'b0;
    tick(); chk_st("t5_finish", 4, 0, 0, 1);
    tick(); chk_st("t5_idle", 4, 0, 0, 0);
    tick(); chk_st("t5_idle_hold", 4, 0, 0, 0);
    bus.mode_manual = 1'b0;
    bus.chan_mask   = 5'b00000;
    bus.enable      = 1'b1;
    tick(); chk_st("t5_mask0_a", 4, 0, 0, 0);
    tick(); chk_st("t5_mask0_b", 4, 0, 0, 0);

    // Single-bit mask with dwell 0 (acts as 1), then async reset in HOLD
    bus.chan_mask = 5'b00010;
    bus.dwell     = 16'd0;
    tick(); chk_st("t6_load", 1, 0, 0, 1);
    tick(); chk_st("t6_sv", 1, 1, 0, 1);
    tick(); chk_st("t6_single", 1, 0, 1, 1);
    tick(); chk_st("t6_sv2", 1, 1, 0, 1);
    rst = 1'b1;
    #1;
    chk_st("t6_async_rst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk_st("t6_rst_held", 0, 0, 0, 0);
    tick(); chk_st("t6_restart", 1, 0, 0, 1);
    tick(); chk_st("t6_restart_sv", 1, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_controller.md
# display_scan_controller

Sequencer for the solar-monitor display path. It drives the one-hot 5-bit `select` of the registered 5:1 display mux, so the voltage, current, power, temperature and efficiency readings are shown in turn for a programmable dwell time. It also supports a manual (pinned) channel and produces `sample_valid` and `frame_done` strobes aligned to the mux's one-cycle register latency. It sits between the user-project top and the display mux, replacing the constant select tie-off.

## Interface
Parameters:
- `DWELL_W`, 16, width of the dwell counter and `dwell` input.

Ports:
- `clk`  in  1  system clock; reset `rst`, asynchronous, active-high.
- `rst`  in  1  asynchronous active-high reset.
- `enable`  in  1  run scanning; sampled at each dwell boundary.
- `mode_manual`  in  1  1 = pin the channel given by `manual_sel`; 0 = auto-rotate.
- `manual_sel`  in  3  channel index 0..4 (voltage, current, power, temperature, efficiency); 5..7 is treated as 0.
- `chan_mask`  in  5  per-channel enable for auto-rotation; bit i = channel i.
- `dwell`  in  DWELL_W  HOLD length in cycles; 0 is treated as 1.
- `select`  out  5  registered one-hot mux select.
- `chan_id`  out  3  binary index of `select`.
- `sample_valid`  out  1  one-cycle pulse: the mux output holds channel `chan_id`.
- `frame_done`  out  1  one-cycle pulse: the rotation wrapped.
- `busy`  out  1  high when not in IDLE.

## Operation
- States: IDLE, SETTLE, HOLD. State, counter and all outputs are registered.
- Reset values: state IDLE, `select`=5'b00001, `chan_id`=0, `sample_valid`=0, `frame_done`=0, `busy`=0, counter 0.
- IDLE:
  - `enable`=1 and `mode_manual`=1: load `manual_sel`, go to SETTLE.
  - `enable`=1, auto mode, `chan_mask`≠0: load the lowest set mask bit, go to SETTLE.
  - `chan_mask`=0 in auto mode: stay in IDLE; `select` holds its value.
- SETTLE: lasts exactly 1 cycle, then HOLD; the counter clears.
- HOLD:
  - `sample_valid` is high in the first HOLD cycle only.
  - The counter increments each cycle; HOLD ends in the cycle where counter = max(`dwell`,1)−1.
- End of HOLD:
  - `enable`=0: go to IDLE; `select` is held.
  - Manual mode: reload `manual_sel`, go to SETTLE. The refresh pulse repeats every dwell period; `frame_done` never fires.
  - Auto mode: next channel = the next set bit of the current `chan_mask` above the current channel, wrapping to the lowest. If that index ≤ current index, pulse `frame_done` in the same cycle the new `select` is registered. Go to SETTLE.
  - Auto mode with `chan_mask`=0 at the boundary: go to IDLE.
- Single-bit mask: the block re-enters SETTLE on the same channel and pulses `frame_done` every dwell.
- Manual override: a change of `manual_sel` (or any rising of `mode_manual`) during HOLD aborts the dwell; the new select is loaded next cycle and the block goes to SETTLE. Falling `mode_manual` takes effect at the next dwell boundary.
- `dwell` and `chan_mask` are sampled only at load/boundary; mid-dwell changes do not shorten the current HOLD.
- `chan_id` always equals the encode of `select`.

## Timing
- `select` changes at edge E0. The mux registers it at E1. `sample_valid` is high from E1 to E2, coinciding with the first valid mux output.
- Period per channel = 1 (SETTLE) + max(`dwell`,1) cycles.
- From IDLE with `enable` rising at edge E: `select` updates at E+1 and `sample_valid` rises at E+2.
- `rst` mid-operation: all outputs return to reset values asynchronously; scanning restarts from IDLE after release.
- `busy`=1 in SETTLE and HOLD.

## Test plan
- Reset, then `enable`=1, mask=5'b11111, dwell=3 → `select` steps 00001,00010,00100,01000,10000 every 4 cycles; one `sample_valid` per step; `frame_done` with the return to 00001.
- mask=5'b10100, dwell=1 → `select` alternates 00100/10000 every 2 cycles; `frame_done` on each 10000→00100 step.
- `mode_manual`=1, `manual_sel`=3, dwell=2 → `select`=01000 constant; `sample_valid` every 3 cycles; no `frame_done`. Set `manual_sel`=6 → `select`=00001.
- Change `manual_sel` 1→4 mid-HOLD → `select`=10000 on the next edge and `sample_valid` 1 cycle later, without waiting for the dwell to end.
- `enable` dropped mid-HOLD → the current dwell completes, then IDLE with `busy`=0 and `select` held. mask=0 with `enable`=1 → stays IDLE.
- Assert `rst` during HOLD → `select`=00001 and all strobes 0 immediately. dwell=0 behaves exactly as dwell=1.
